// File: rtl/cache_ram_arbiter_if.sv
// Bundles the I-cache, D-cache and RAM-side signals of the cache/RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the caches-plus-RAM environment.
interface cache_ram_arbiter_if #(
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 3,
  parameter int BLOCK_WIDTH  = DATA_WIDTH << OFFSET_WIDTH
);
  logic                   ic_en_in;
  logic [ADDR_WIDTH-1:0]  ic_addr_in;
  logic                   ic_ready_out;
  logic [BLOCK_WIDTH-1:0] ic_block_out;

  logic                   dc_en_in;
  logic                   dc_write_in;
  logic [ADDR_WIDTH-1:0]  dc_addr_in;
  logic [BLOCK_WIDTH-1:0] dc_block_in;
  logic                   dc_ready_out;
  logic [BLOCK_WIDTH-1:0] dc_block_out;

  logic                   ram_ready;
  logic [BLOCK_WIDTH-1:0] block_from_ram;
  logic                   ram_en_out;
  logic                   ram_write_out;
  logic [ADDR_WIDTH-1:0]  ram_addr_out;
  logic [BLOCK_WIDTH-1:0] ram_block_out;

  logic [1:0]             grant_state;

  modport slave (
    input  ic_en_in, ic_addr_in,
    output ic_ready_out, ic_block_out,
    input  dc_en_in, dc_write_in, dc_addr_in, dc_block_in,
    output dc_ready_out, dc_block_out,
    input  ram_ready, block_from_ram,
    output ram_en_out, ram_write_out, ram_addr_out, ram_block_out,
    output grant_state
  );

  modport master (
    output ic_en_in, ic_addr_in,
    input  ic_ready_out, ic_block_out,
    output dc_en_in, dc_write_in, dc_addr_in, dc_block_in,
    input  dc_ready_out, dc_block_out,
    output ram_ready, block_from_ram,
    input  ram_en_out, ram_write_out, ram_addr_out, ram_block_out,
    input  grant_state
  );
endinterface

// File: rtl/cache_ram_arbiter.sv
// Round-robin arbiter sharing one block-wide RAM port between the I-cache and D-cache refill paths.
// All RAM-side and cache-side outputs are registered; one transaction is in flight at a time.
module cache_ram_arbiter #(
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 3
) (
  input logic                clk,
  input logic                rst,
  cache_ram_arbiter_if.slave bus
);
  localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   lastGrantD_q;
  logic                   ramEn_q;
  logic                   ramWrite_q;
  logic [ADDR_WIDTH-1:0]  ramAddr_q;
  logic [BLOCK_WIDTH-1:0] ramBlock_q;
  logic                   icReady_q;
  logic                   dcReady_q;
  logic [BLOCK_WIDTH-1:0] icBlock_q;
  logic [BLOCK_WIDTH-1:0] dcBlock_q;
  logic                   pickD;

  // On a tie the D-cache wins only when the I-cache was the previous winner.
  assign pickD = bus.dc_en_in && (!bus.ic_en_in || !lastGrantD_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lastGrantD_q <= 1'b0;
      ramEn_q      <= 1'b0;
      ramWrite_q   <= 1'b0;
      ramAddr_q    <= '0;
      ramBlock_q   <= '0;
      icReady_q    <= 1'b0;
      dcReady_q    <= 1'b0;
      icBlock_q    <= '0;
      dcBlock_q    <= '0;
    end else begin
      icReady_q <= 1'b0;
      dcReady_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickD) begin
            state_q      <= BUSY_D;
            lastGrantD_q <= 1'b1;
            ramEn_q      <= 1'b1;
            ramWrite_q   <= bus.dc_write_in;
            ramAddr_q    <= bus.dc_addr_in;
            ramBlock_q   <= bus.dc_block_in;
          end else if (bus.ic_en_in) begin
            state_q      <= BUSY_I;
            lastGrantD_q <= 1'b0;
            ramEn_q      <= 1'b1;
            ramWrite_q   <= 1'b0;
            ramAddr_q    <= bus.ic_addr_in;
            ramBlock_q   <= '0;
          end
        end
        BUSY_I: begin
          if (bus.ram_ready) begin
            state_q   <= DONE;
            ramEn_q   <= 1'b0;
            icReady_q <= 1'b1;
            icBlock_q <= bus.block_from_ram;
          end
        end
        BUSY_D: begin
          if (bus.ram_ready) begin
            state_q   <= DONE;
            ramEn_q   <= 1'b0;
            dcReady_q <= 1'b1;
            if (!ramWrite_q) begin
              dcBlock_q <= bus.block_from_ram;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en_out    = ramEn_q;
  assign bus.ram_write_out = ramWrite_q;
  assign bus.ram_addr_out  = ramAddr_q;
  assign bus.ram_block_out = ramBlock_q;
  assign bus.ic_ready_out  = icReady_q;
  assign bus.ic_block_out  = icBlock_q;
  assign bus.dc_ready_out  = dcReady_q;
  assign bus.dc_block_out  = dcBlock_q;
  assign bus.grant_state   = state_q;

  readyExclusive: assert property (@(posedge clk) disable iff (rst)
    !(icReady_q && dcReady_q));

  readyOnlyInDone: assert property (@(posedge clk) disable iff (rst)
    (icReady_q || dcReady_q) |-> (state_q == DONE));

  ramEnOnlyWhenBusy: assert property (@(posedge clk) disable iff (rst)
    ramEn_q |-> (state_q == BUSY_I || state_q == BUSY_D));
endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Scoreboard bench for cache_ram_arbiter: tests push expected completions, a monitor pops them on each
// ready pulse; a behavioural RAM answers after a programmable latency and stores write-backs.
module tb_cache_ram_arbiter;
  typedef struct packed {
    logic         isD;
    logic [255:0] block;
  } expEntry_t;

  logic clk;
  logic rst;

  cache_ram_arbiter_if bus ();

  cache_ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  expEntry_t    expQ[$];
  expEntry_t    monEntry;
  int           assertCount;
  int           failCount;
  int           readyCount;
  int           ramLatency;
  int           ramCnt;
  logic         idlePulse;
  logic [255:0] ramMem [logic [29:0]];

  localparam logic [255:0] BLK_A5   = {32{8'hA5}};
  localparam logic [255:0] BLK_WB1  = {8{32'h12345678}};
  localparam logic [255:0] BLK_BEEF = {8{32'hDEADBEEF}};
  localparam logic [255:0] BLK_040  = {8{32'h11110040}};
  localparam logic [255:0] BLK_080  = {8{32'h22220080}};
  localparam logic [255:0] BLK_WB2  = {8{32'hCAFEF00D}};
  localparam logic [255:0] BLK_WB3  = {8{32'h0BADC0DE}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  task automatic expectTxn(input logic isD, input logic [255:0] block);
    expEntry_t e;
    e.isD   = isD;
    e.block = block;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic isD, input logic write, input logic [29:0] addr,
                               input logic [255:0] blk);
    if (isD) begin
      bus.dc_en_in    = 1'b1;
      bus.dc_write_in = write;
      bus.dc_addr_in  = addr;
      bus.dc_block_in = blk;
    end else begin
      bus.ic_en_in   = 1'b1;
      bus.ic_addr_in = addr;
    end
  endtask

  // Requester side: waits for its own ready pulse and drops the request during the DONE cycle.
  task automatic waitDone(input logic isD);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (isD ? bus.dc_ready_out : bus.ic_ready_out) begin
        if (isD) begin
          bus.dc_en_in    = 1'b0;
          bus.dc_write_in = 1'b0;
        end else begin
          bus.ic_en_in = 1'b0;
        end
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL readyTimeout: got no ready pulse on %s within 200 cycles, required one",
               isD ? "dc" : "ic");
    end
  endtask

  task automatic resetDut();
    rst             = 1'b1;
    bus.ic_en_in    = 1'b0;
    bus.ic_addr_in  = '0;
    bus.dc_en_in    = 1'b0;
    bus.dc_write_in = 1'b0;
    bus.dc_addr_in  = '0;
    bus.dc_block_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural RAM: completes after ramLatency enabled cycles, stores write-backs.
  initial begin
    bus.ram_ready      = 1'b0;
    bus.block_from_ram = '0;
    ramCnt             = 0;
    forever begin
      @(negedge clk);
      bus.ram_ready = 1'b0;
      if (idlePulse) begin
        bus.ram_ready      = 1'b1;
        bus.block_from_ram = '1;
        idlePulse          = 1'b0;
      end else if (bus.ram_en_out) begin
        ramCnt++;
        if (ramCnt == ramLatency) begin
          ramCnt        = 0;
          bus.ram_ready = 1'b1;
          if (bus.ram_write_out) begin
            ramMem[bus.ram_addr_out] = bus.ram_block_out;
          end else begin
            bus.block_from_ram = ramMem.exists(bus.ram_addr_out) ? ramMem[bus.ram_addr_out] : '0;
          end
        end
      end else begin
        ramCnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.ic_ready_out || bus.dc_ready_out) begin
        readyCount++;
        checkOutput("readyExclusive", {255'd0, bus.ic_ready_out & bus.dc_ready_out}, '0);
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedReady: got ic=%0b dc=%0b required no pulse",
                   bus.ic_ready_out, bus.dc_ready_out);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("readyPort", {255'd0, bus.dc_ready_out}, {255'd0, monEntry.isD});
          if (monEntry.isD) checkOutput("dcBlock", bus.dc_block_out, monEntry.block);
          else              checkOutput("icBlock", bus.ic_block_out, monEntry.block);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    readyCount  = 0;
    ramLatency  = 4;
    idlePulse   = 1'b0;
    ramMem[30'h100] = BLK_A5;
    ramMem[30'h040] = BLK_040;
    ramMem[30'h080] = BLK_080;

    // Reset values, then a stray RAM strobe while idle.
    resetDut();
    checkOutput("rstRamEn",    {255'd0, bus.ram_en_out}, '0);
    checkOutput("rstRamWrite", {255'd0, bus.ram_write_out}, '0);
    checkOutput("rstRamAddr",  {226'd0, bus.ram_addr_out}, '0);
    checkOutput("rstRamBlock", bus.ram_block_out, '0);
    checkOutput("rstIcReady",  {255'd0, bus.ic_ready_out}, '0);
    checkOutput("rstDcReady",  {255'd0, bus.dc_ready_out}, '0);
    checkOutput("rstIcBlock",  bus.ic_block_out, '0);
    checkOutput("rstDcBlock",  bus.dc_block_out, '0);
    checkOutput("rstState",    {254'd0, bus.grant_state}, 256'd0);
    idlePulse = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idleStrobeIgnored", readyCount, 0);
    checkOutput("idleStrobeState", {254'd0, bus.grant_state}, 256'd0);

    // I-cache refill alone.
    expectTxn(1'b0, BLK_A5);
    applyStimulus(1'b0, 1'b0, 30'h100, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("iBusyRamEn",    {255'd0, bus.ram_en_out}, 256'd1);
      checkOutput("iBusyRamWrite", {255'd0, bus.ram_write_out}, '0);
      checkOutput("iBusyRamAddr",  {226'd0, bus.ram_addr_out}, 256'h100);
      checkOutput("iBusyState",    {254'd0, bus.grant_state}, 256'd1);
    end
    waitDone(1'b0);
    checkOutput("iDoneState", {254'd0, bus.grant_state}, 256'd3);
    checkOutput("iDoneRamEn", {255'd0, bus.ram_en_out}, '0);
    repeat (3) @(negedge clk);
    checkOutput("iBlockHeld", bus.ic_block_out, BLK_A5);
    checkOutput("iReadyDropped", {255'd0, bus.ic_ready_out}, '0);

    // D-cache write-back; write data must stay latched when the input changes.
    expectTxn(1'b1, '0);
    applyStimulus(1'b1, 1'b1, 30'h2C0, BLK_WB1);
    @(negedge clk);
    checkOutput("dWbRamWrite", {255'd0, bus.ram_write_out}, 256'd1);
    checkOutput("dWbRamAddr",  {226'd0, bus.ram_addr_out}, 256'h2C0);
    checkOutput("dWbState",    {254'd0, bus.grant_state}, 256'd2);
    bus.dc_block_in = BLK_BEEF;
    @(negedge clk);
    checkOutput("dWbBlockHeld", bus.ram_block_out, BLK_WB1);
    waitDone(1'b1);

    // Ties after reset: D first, then I after one DONE and one IDLE cycle.
    resetDut();
    expectTxn(1'b1, BLK_WB1);
    expectTxn(1'b0, BLK_040);
    applyStimulus(1'b0, 1'b0, 30'h040, '0);
    applyStimulus(1'b1, 1'b0, 30'h2C0, '0);
    @(negedge clk);
    checkOutput("tie1Winner", {254'd0, bus.grant_state}, 256'd2);
    checkOutput("tie1Addr",   {226'd0, bus.ram_addr_out}, 256'h2C0);
    waitDone(1'b1);
    checkOutput("tie1DoneState", {254'd0, bus.grant_state}, 256'd3);
    @(negedge clk);
    checkOutput("tie1GapState", {254'd0, bus.grant_state}, 256'd0);
    checkOutput("tie1GapRamEn", {255'd0, bus.ram_en_out}, '0);
    @(negedge clk);
    checkOutput("tie1SecondState", {254'd0, bus.grant_state}, 256'd1);
    checkOutput("tie1SecondAddr",  {226'd0, bus.ram_addr_out}, 256'h040);
    waitDone(1'b0);

    expectTxn(1'b1, BLK_080);
    applyStimulus(1'b1, 1'b0, 30'h080, '0);
    waitDone(1'b1);

    expectTxn(1'b0, BLK_A5);
    expectTxn(1'b1, BLK_080);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 30'h100, '0);
    applyStimulus(1'b1, 1'b1, 30'h0C0, BLK_WB2);
    @(negedge clk);
    checkOutput("tie2Winner", {254'd0, bus.grant_state}, 256'd1);
    waitDone(1'b0);
    waitDone(1'b1);

    // D re-requests right after its DONE while I is pending: I must win.
    expectTxn(1'b1, BLK_040);
    expectTxn(1'b0, BLK_080);
    expectTxn(1'b1, BLK_040);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 30'h040, '0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 30'h080, '0);
    waitDone(1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 30'h300, BLK_WB3);
    @(negedge clk);
    checkOutput("starveWinner", {254'd0, bus.grant_state}, 256'd1);
    checkOutput("starveAddr",   {226'd0, bus.ram_addr_out}, 256'h080);
    waitDone(1'b0);
    waitDone(1'b1);

    // Reset during BUSY_D aborts the transaction without a ready pulse.
    ramLatency = 100;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 30'h100, '0);
    repeat (2) @(negedge clk);
    checkOutput("abortBusy", {254'd0, bus.grant_state}, 256'd2);
    readyCount = 0;
    rst             = 1'b1;
    bus.dc_en_in    = 1'b0;
    bus.dc_write_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortRamEn",   {255'd0, bus.ram_en_out}, '0);
    checkOutput("abortState",   {254'd0, bus.grant_state}, 256'd0);
    checkOutput("abortDcBlock", bus.dc_block_out, '0);
    repeat (5) @(negedge clk);
    checkOutput("abortNoReady", readyCount, 0);
    ramLatency = 4;

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
